// File: rtl/light_buf_reader.sv
// Read side of the zone-brightness buffer: scans NUM_ZONES bytes from a 1-cycle-latency RAM
// and streams them in zone order on valid/ready through a 2-entry output buffer.
module light_buf_reader #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int NUM_ZONES = 576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_ZONES - 1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [ADDR_W:0]   beat_q, beat_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;
    logic              pop, issue;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        count_d      = count_q;
        pop          = (count_q != 2'd0) && m_ready;
        issue        = (state_q == READ) &&
                       (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
        inflight_d   = issue;
        frame_done_d = pop && (beat_q == LAST_IDX);
        overrun_d    = frame_start && (state_q != IDLE);

        // Pop shifts the buffer first, so a same-cycle capture lands in the freed slot.
        if (pop) begin
            buf0_d  = buf1_q;
            count_d = count_d - 2'd1;
            beat_d  = beat_q + ONE;
        end
        if (inflight_q) begin
            if (count_d == 2'd0) begin
                buf0_d = rd_data;
            end else begin
                buf1_d = rd_data;
            end
            count_d = count_d + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = READ;
                    addr_d  = '0;
                    beat_d  = '0;
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = addr_q + ONE;
                    if (addr_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Stay busy through the frame_done cycle so a coincident frame_start counts as overrun.
                if (frame_done_q && (count_q == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beat_q       <= '0;
            inflight_q   <= 1'b0;
            count_q      <= '0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beat_q       <= beat_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rd_en      = issue;
    assign rd_addr    = addr_q[ADDR_W-1:0];
    assign m_valid    = (count_q != 2'd0);
    assign m_data     = buf0_q;
    assign m_last     = m_valid && (beat_q == LAST_IDX);
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_light_buf_reader.sv
// Bench for light_buf_reader: start-of-frame vector table, then randomized frames checked
// against a zone-order stream model, plus a 2**ADDR_W zone instance.
module tb_light_buf_reader;
    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int NZ  = 576;
    localparam int NZB = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          frame_start, rd_en, m_valid, m_last, m_ready, busy, frame_done, overrun;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, m_data;

    logic          frame_start_b, rd_en_b, m_valid_b, m_last_b, m_ready_b, busy_b, frame_done_b, overrun_b;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_b, m_data_b;

    logic [DW-1:0] ram [0:NZB-1];

    light_buf_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_ZONES(NZ)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_ready(m_ready), .busy(busy), .frame_done(frame_done), .overrun(overrun));

    light_buf_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_ZONES(NZB)) dut_big (
        .clk(clk), .rst(rst), .frame_start(frame_start_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .m_valid(m_valid_b), .m_data(m_data_b), .m_last(m_last_b),
        .m_ready(m_ready_b), .busy(busy_b), .frame_done(frame_done_b), .overrun(overrun_b));

    always @(posedge clk) begin
        if (rd_en)   rd_data   <= ram[rd_addr];
        if (rd_en_b) rd_data_b <= ram[rd_addr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: a frame is the stream ram[0..NZ-1], each byte accepted once.
    bit            mon_on = 0;
    bit            model_busy = 0, done_exp = 0, over_exp = 0, prev_stall = 0, after_rst = 0;
    int            exp_idx = 0, issued = 0, frames_done = 0, n_over = 0;
    int            t_start = 0, t_first = -1, t_last = -1;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic monitor();
        bit last_hs;
        last_hs = 1'b0;
        if (after_rst) begin
            chk("rst_m_valid", 32'(m_valid), 0);
            chk("rst_rd_addr", 32'(rd_addr), 0);
            chk("rst_busy", 32'(busy), 0);
        end
        chk("busy", 32'(busy), 32'(model_busy));
        chk("frame_done", 32'(frame_done), 32'(done_exp));
        chk("overrun", 32'(overrun), 32'(over_exp));
        if (overrun) n_over++;
        if (prev_stall) begin
            chk("hold_valid", 32'(m_valid), 1);
            chk("hold_data", 32'(m_data), 32'(prev_data));
            chk("hold_last", 32'(m_last), 32'(prev_last));
        end
        if (rd_en) begin
            chk("rd_en_in_frame", 32'(model_busy && issued < NZ), 1);
            chk("rd_addr", 32'(rd_addr), 32'(issued));
            issued++;
        end
        if (m_valid) begin
            if (t_first < 0) t_first = cyc;
            chk("valid_in_frame", 32'(model_busy && exp_idx < NZ), 1);
            chk("m_last", 32'(m_last), 32'(exp_idx == NZ - 1));
            if (m_ready && exp_idx < NZ) begin
                chk("m_data", 32'(m_data), 32'(ram[exp_idx]));
                if (exp_idx == NZ - 1) begin
                    last_hs = 1'b1;
                    t_last  = cyc;
                end
                exp_idx++;
            end
        end
        chk("outstanding", 32'((issued - exp_idx) <= 2), 1);

        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        over_exp   = frame_start && model_busy;
        after_rst  = 1'b0;
        if (rst) begin
            model_busy = 0; done_exp = 0; over_exp = 0; prev_stall = 0;
            after_rst  = 1; exp_idx = 0; issued = 0;
        end else if (frame_start && !model_busy) begin
            model_busy = 1; exp_idx = 0; issued = 0; t_start = cyc; t_first = -1; t_last = -1;
            done_exp   = 0;
        end else begin
            if (done_exp) begin
                model_busy = 0;
                frames_done++;
            end
            done_exp = last_hs;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_on) monitor();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: m_ready always 1; mode 1: random m_ready. inj: frame_start at beat 100 and on frame_done.
    task automatic run_frame(input int mode, input bit inj);
        int start_frames, start_over, guard;
        bit inj100, injdone;
        start_frames = frames_done;
        start_over   = n_over;
        guard = 0; inj100 = 0; injdone = 0;
        frame_start = 1'b1;
        m_ready = 1'b1;
        step();
        while (frames_done == start_frames && guard < 5000) begin
            m_ready     = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            frame_start = 1'b0;
            if (inj && !inj100 && exp_idx == 100) begin frame_start = 1'b1; inj100 = 1; end
            if (inj && !injdone && done_exp)      begin frame_start = 1'b1; injdone = 1; end
            step();
            guard++;
        end
        frame_start = 1'b0;
        chk("frame_timeout", 32'(guard < 5000), 1);
        chk("frame_beats", 32'(exp_idx), NZ);
        if (mode == 0) begin
            chk("first_valid_latency", 32'(t_first - t_start), 3);
            chk("last_byte_latency", 32'(t_last - t_start), 32'(2 + NZ));
        end
        for (int i = 0; i < 4; i++) step();
        chk("idle_after_frame", 32'(busy), 0);
        if (inj) chk("overrun_pulses", 32'(n_over - start_over), 2);
    endtask

    typedef struct {
        logic          fs;
        logic          rdy;
        logic          e_rd_en;
        logic [AW-1:0] e_addr;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_busy;
    } vec_t;

    function automatic vec_t mk(input bit fs, input bit rdy, input bit en, input int addr,
                                input bit v, input int d, input bit b);
        vec_t r;
        r.fs = fs; r.rdy = rdy; r.e_rd_en = en; r.e_addr = AW'(addr);
        r.e_valid = v; r.e_data = DW'(d); r.e_busy = b;
        return r;
    endfunction

    vec_t tv [25];

    initial begin
        // Start of frame with m_ready low for 21 cycles, then released (RAM[i] = i).
        tv[0] = mk(1, 0, 0, 0, 0, 0, 0);
        tv[1] = mk(0, 0, 1, 0, 0, 0, 1);
        tv[2] = mk(0, 0, 1, 1, 0, 0, 1);
        for (int k = 3; k <= 20; k++) tv[k] = mk(0, 0, 0, 2, 1, 0, 1);
        tv[21] = mk(0, 1, 1, 2, 1, 0, 1);
        tv[22] = mk(0, 1, 1, 3, 1, 1, 1);
        tv[23] = mk(0, 1, 1, 4, 1, 2, 1);
        tv[24] = mk(0, 1, 1, 5, 1, 3, 1);

        for (int i = 0; i < NZB; i++) ram[i] = DW'(i);
        rst = 1'b1; frame_start = 1'b0; m_ready = 1'b0;
        frame_start_b = 1'b0; m_ready_b = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rd_en", 32'(rd_en), 0);
        chk("reset_m_valid", 32'(m_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_frame_done", 32'(frame_done), 0);
        chk("reset_overrun", 32'(overrun), 0);
        step();

        for (int k = 0; k < 25; k++) begin
            frame_start = tv[k].fs;
            m_ready     = tv[k].rdy;
            @(negedge clk);
            chk("tv_rd_en", 32'(rd_en), 32'(tv[k].e_rd_en));
            chk("tv_rd_addr", 32'(rd_addr), 32'(tv[k].e_addr));
            chk("tv_m_valid", 32'(m_valid), 32'(tv[k].e_valid));
            if (tv[k].e_valid) chk("tv_m_data", 32'(m_data), 32'(tv[k].e_data));
            chk("tv_busy", 32'(busy), 32'(tv[k].e_busy));
            step();
        end
        frame_start = 1'b0;
        rst = 1'b1; step(); step(); rst = 1'b0; step();

        mon_on = 1;
        run_frame(0, 0);
        for (int i = 0; i < NZB; i++) ram[i] = DW'($urandom);
        run_frame(1, 0);
        run_frame(1, 0);
        run_frame(0, 1);

        // Reset mid-frame at beat 300 while a byte is valid, then restart.
        frame_start = 1'b1; m_ready = 1'b1;
        step();
        frame_start = 1'b0;
        for (int g = 0; g < 2000; g++) begin
            if (exp_idx == 300 && m_valid) break;
            step();
        end
        chk("reset_point_reached", 32'(exp_idx == 300 && m_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        run_frame(0, 0);
        mon_on = 0;

        // Full 2**ADDR_W zone frame on the second instance.
        begin
            int bi, bissue, guard;
            bit bdone;
            bi = 0; bissue = 0; guard = 0; bdone = 0;
            frame_start_b = 1'b1;
            step();
            frame_start_b = 1'b0;
            while (!bdone && guard < 1500) begin
                @(negedge clk);
                if (rd_en_b) begin
                    chk("big_rd_addr", 32'(rd_addr_b), 32'(bissue));
                    bissue++;
                end
                if (m_valid_b) begin
                    if (bi < NZB) begin
                        chk("big_m_data", 32'(m_data_b), 32'(ram[bi]));
                        chk("big_m_last", 32'(m_last_b), 32'(bi == NZB - 1));
                    end else begin
                        chk("big_extra_beat", 32'(bi), NZB - 1);
                    end
                    bi++;
                end
                if (frame_done_b) bdone = 1;
                guard++;
                step();
            end
            chk("big_timeout", 32'(bdone), 1);
            chk("big_issued", 32'(bissue), NZB);
            chk("big_beats", 32'(bi), NZB);
            step();
            @(negedge clk);
            chk("big_idle", 32'(busy_b), 0);
            chk("big_overrun", 32'(overrun_b), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
